// File: rtl/eth_rx_crc_check.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | eth_rx_crc_check: strips preamble/SFD, forwards payload, holds back FCS, |
// | and reports length and CRC/runt/oversize status per frame.              |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module eth_rx_crc_check #(
   parameter int MAX_LEN = 1518,
   parameter int LEN_W   = 11
) (
   input  logic             clk50,
   input  logic             reset,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   input  logic             in_eop,
   output logic [7:0]       out_data,
   output logic             out_valid,
   output logic             out_sop,
   output logic             frame_done,
   output logic [LEN_W-1:0] frame_len,
   output logic             crc_ok,
   output logic             runt,
   output logic             toolong
);

   localparam logic [1:0] S_HUNT = 2'd0;
   localparam logic [1:0] S_DATA = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;
   localparam logic [1:0] S_DROP = 2'd3;

   localparam logic [7:0]       C_PRE      = 8'h55;
   localparam logic [7:0]       C_SFD      = 8'hD5;
   localparam logic [31:0]      C_CRC_INIT = 32'hFFFF_FFFF;
   localparam logic [31:0]      C_POLY     = 32'hEDB8_8320;
   localparam logic [31:0]      C_RESIDUE  = 32'hC704_DD7B;
   localparam logic [LEN_W-1:0] C_LEN_SAT  = '1;
   localparam logic [LEN_W-1:0] C_MAX_LEN  = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] C_MIN_LEN  = LEN_W'(4);
   localparam logic [2:0]       C_DL_FULL  = 3'd4;

   function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'd0, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ C_POLY) : (c >> 1);
      end
      return c;
   endfunction

   logic [1:0]       state_q, state_d;
   logic [31:0]      crc_q, crc_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] emit_q, emit_d;
   logic [7:0]       dl_q [0:3];
   logic [7:0]       dl_d [0:3];
   logic [2:0]       fill_q, fill_d;
   logic [7:0]       out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             out_sop_q, out_sop_d;
   logic             frame_done_q, frame_done_d;
   logic [LEN_W-1:0] frame_len_q, frame_len_d;
   logic             crc_ok_q, crc_ok_d;
   logic             runt_q, runt_d;
   logic             toolong_q, toolong_d;

   logic [31:0]      w_crc_rev;
   logic             w_finish;

   // Residue constant is in MSB-first order; the register runs reflected.
   assign w_crc_rev = {<<{crc_q}};
   // A byte arriving with eop detours through S_FIN so its emission never
   // coincides with frame_done.
   assign w_finish  = ((state_q == S_DATA) && in_eop && !in_valid) || (state_q == S_FIN);

   always_ff @(posedge clk50) begin
      if (reset) begin
         state_q      <= S_HUNT;
         crc_q        <= C_CRC_INIT;
         cnt_q        <= '0;
         emit_q       <= '0;
         fill_q       <= '0;
         for (int i = 0; i < 4; i++) dl_q[i] <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         out_sop_q    <= 1'b0;
         frame_done_q <= 1'b0;
         frame_len_q  <= '0;
         crc_ok_q     <= 1'b0;
         runt_q       <= 1'b0;
         toolong_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         crc_q        <= crc_d;
         cnt_q        <= cnt_d;
         emit_q       <= emit_d;
         fill_q       <= fill_d;
         for (int i = 0; i < 4; i++) dl_q[i] <= dl_d[i];
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         out_sop_q    <= out_sop_d;
         frame_done_q <= frame_done_d;
         frame_len_q  <= frame_len_d;
         crc_ok_q     <= crc_ok_d;
         runt_q       <= runt_d;
         toolong_q    <= toolong_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_HUNT: begin
            if (in_valid) begin
               if (in_data == C_SFD)      state_d = S_DATA;
               else if (in_data != C_PRE) state_d = S_DROP;
            end
         end
         S_DATA: begin
            if (in_eop) state_d = in_valid ? S_FIN : S_HUNT;
         end
         S_FIN:  state_d = S_HUNT;
         S_DROP: begin
            if (in_eop) state_d = S_HUNT;
         end
         default: state_d = S_HUNT;
      endcase
   end

   always_comb begin
      crc_d        = crc_q;
      cnt_d        = cnt_q;
      emit_d       = emit_q;
      fill_d       = fill_q;
      for (int i = 0; i < 4; i++) dl_d[i] = dl_q[i];
      out_data_d   = out_data_q;
      out_valid_d  = 1'b0;
      out_sop_d    = 1'b0;
      frame_done_d = 1'b0;
      frame_len_d  = frame_len_q;
      crc_ok_d     = crc_ok_q;
      runt_d       = runt_q;
      toolong_d    = toolong_q;

      if ((state_q == S_HUNT) && in_valid && (in_data == C_SFD)) begin
         crc_d  = C_CRC_INIT;
         cnt_d  = '0;
         emit_d = '0;
         fill_d = '0;
      end

      if ((state_q == S_DATA) && in_valid) begin
         crc_d = crc_byte(crc_q, in_data);
         if (cnt_q != C_LEN_SAT) cnt_d = cnt_q + 1'b1;
         dl_d[0] = in_data;
         for (int i = 1; i < 4; i++) dl_d[i] = dl_q[i-1];
         if (fill_q == C_DL_FULL) begin
            out_data_d  = dl_q[3];
            out_valid_d = 1'b1;
            out_sop_d   = (emit_q == '0);
            if (emit_q != C_LEN_SAT) emit_d = emit_q + 1'b1;
         end else begin
            fill_d = fill_q + 1'b1;
         end
      end

      if (w_finish) begin
         frame_done_d = 1'b1;
         frame_len_d  = emit_q;
         runt_d       = (cnt_q < C_MIN_LEN);
         crc_ok_d     = (cnt_q >= C_MIN_LEN) && (w_crc_rev == C_RESIDUE);
         toolong_d    = (cnt_q > C_MAX_LEN);
      end
   end

   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign out_sop    = out_sop_q;
   assign frame_done = frame_done_q;
   assign frame_len  = frame_len_q;
   assign crc_ok     = crc_ok_q;
   assign runt       = runt_q;
   assign toolong    = toolong_q;

endmodule
`default_nettype wire
